// File: rtl/seg7_pkg.sv
// Shared constants, payload type and select decoder for the seven-segment scan multiplexer.
package seg7_pkg;

    localparam int unsigned NUM_DIG = 6;
    localparam int unsigned IDX_W   = 3;

    localparam logic [7:0]         SEG_OFF = 8'hFF;
    localparam logic [NUM_DIG-1:0] SEL_OFF = 6'h3F;

    typedef struct packed {
        logic       dp;
        logic [6:0] segs;
    } seg_code_t;

    // Active-low one-hot digit select for the given index.
    function automatic logic [NUM_DIG-1:0] sel_decode(input logic [IDX_W-1:0] idx);
        return ~(NUM_DIG'(1) << idx);
    endfunction

endpackage

// File: rtl/seg7_scan_prescaler.sv
// Slot counter: counts 0..REFRESH_CNT-1, flags the wrap cycle, cleared while clr is high.
module seg7_scan_prescaler #(
    parameter int unsigned REFRESH_CNT = 50_000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    output logic [$clog2(REFRESH_CNT)-1:0] cnt,
    output logic                           slot_end
);

    localparam int unsigned CW = $clog2(REFRESH_CNT);

    assign slot_end = (cnt == CW'(REFRESH_CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || slot_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Six-digit seven-segment scan multiplexer with frame-aligned shadow capture.
// Optional GHOST_BLANK_EN macro blanks the first BLANK_CNT cycles of every slot.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_CNT = 50_000,
    parameter int unsigned BLANK_CNT   = 500
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [7:0]         in0,
    input  logic [7:0]         in1,
    input  logic [7:0]         in2,
    input  logic [7:0]         in3,
    input  logic [7:0]         in4,
    input  logic [7:0]         in5,
    output logic [7:0]         seg_out,
    output logic [NUM_DIG-1:0] sel,
    output logic               frame_tick
);

    localparam int unsigned CW = $clog2(REFRESH_CNT);

`ifdef GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    logic [CW-1:0]              cnt;
    logic                       slot_end;
    logic                       frame_end_c;
    logic                       blank_c;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           idx_nxt_c;
    seg_code_t [NUM_DIG-1:0]    sh;
    seg_code_t [NUM_DIG-1:0]    in_bus;

    assign in_bus = {in5, in4, in3, in2, in1, in0};

    seg7_scan_prescaler #(
        .REFRESH_CNT (REFRESH_CNT)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (~en),
        .cnt      (cnt),
        .slot_end (slot_end)
    );

    // Digit index advance and dead-time window.
    always_comb begin
        frame_end_c = slot_end && (idx == IDX_W'(NUM_DIG - 1));
        idx_nxt_c   = idx;
        if (slot_end) begin
            idx_nxt_c = frame_end_c ? '0 : idx + IDX_W'(1);
        end
        blank_c = GHOST && (cnt < CW'(BLANK_CNT));
    end

    // Disabled: blank and track inputs so the first enabled edge shows fresh codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            sh         <= {NUM_DIG{SEG_OFF}};
            seg_out    <= SEG_OFF;
            sel        <= SEL_OFF;
            frame_tick <= 1'b0;
        end else if (!en) begin
            idx        <= '0;
            sh         <= in_bus;
            seg_out    <= SEG_OFF;
            sel        <= SEL_OFF;
            frame_tick <= 1'b0;
        end else begin
            idx        <= idx_nxt_c;
            frame_tick <= frame_end_c;
            if (frame_end_c) begin
                sh <= in_bus;
            end
            if (blank_c) begin
                seg_out <= SEG_OFF;
                sel     <= SEL_OFF;
            end else begin
                seg_out <= sh[idx];
                sel     <= sel_decode(idx);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized self-checking bench for seg7_scan_mux against a cycle-count display model.
// Build with GHOST_BLANK_EN to exercise the dead-time variant.
module tb_seg7_scan_mux;

`ifdef GHOST_BLANK_EN
    localparam int RC = 8;
    localparam int BC = 3;
    localparam bit GH = 1'b1;
`else
    localparam int RC = 4;
    localparam int BC = 3;
    localparam bit GH = 1'b0;
`endif
    localparam int FRAME = 6 * RC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] din [6];
    logic [7:0] seg_out;
    logic [5:0] sel;
    logic       frame_tick;

    int         tests = 0;
    int         fails = 0;
    int         n;
    logic [7:0] disp [6];
    logic [7:0] es;
    logic [5:0] esl;
    logic       et;

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .REFRESH_CNT (RC),
        .BLANK_CNT   (BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in0        (din[0]),
        .in1        (din[1]),
        .in2        (din[2]),
        .in3        (din[3]),
        .in4        (din[4]),
        .in5        (din[5]),
        .seg_out    (seg_out),
        .sel        (sel),
        .frame_tick (frame_tick)
    );

    // Model: n = enabled edges since scan start; digit, slot position and frame follow by division.
    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 6; i++) disp[i] = 8'hFF;
    endtask

    task automatic cycle();
        int  d;
        int  p;
        bit  blank;
        if (!en) begin
            es  = 8'hFF;
            esl = 6'h3F;
            et  = 1'b0;
            for (int i = 0; i < 6; i++) disp[i] = din[i];
            n = 0;
        end else begin
            d     = (n / RC) % 6;
            p     = n % RC;
            blank = GH && (p < BC);
            es    = blank ? 8'hFF : disp[d];
            esl   = blank ? 6'h3F : 6'(~(6'b1 << d));
            et    = ((n % FRAME) == FRAME - 1);
            if (et) for (int i = 0; i < 6; i++) disp[i] = din[i];
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < 6; i++) din[i] = 8'h00;
        #12;
        tests += 3;
        if (seg_out !== 8'hFF) begin fails++; $display("FAIL reset_seg got %h want ff", seg_out); end
        if (sel !== 6'h3F)     begin fails++; $display("FAIL reset_sel got %h want 3f", sel); end
        if (frame_tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        #10;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) din[i] = 8'(i + 1);
    endtask

    task automatic test_first_frames();
        for (int k = 0; k < 2 * FRAME; k++) begin
            cycle();
            tests += 4;
            if (seg_out !== es) begin fails++; $display("FAIL ff_seg k=%0d got %h want %h", k, seg_out, es); end
            if (sel !== esl)    begin fails++; $display("FAIL ff_sel k=%0d got %h want %h", k, sel, esl); end
            if (frame_tick !== et) begin fails++; $display("FAIL ff_tick k=%0d got %b want %b", k, frame_tick, et); end
            if (k < FRAME && seg_out !== 8'hFF) begin fails++; $display("FAIL ff_blank_shadow k=%0d got %h want ff", k, seg_out); end
        end
    endtask

    task automatic test_mid_frame_change();
        int guard = 0;
        int seen  = 0;
        while ((((n / RC) % 6) != 1 || (n % RC) != 1) && guard < 4 * FRAME) begin
            cycle();
            guard++;
            tests += 2;
            if (seg_out !== es) begin fails++; $display("FAIL mf_pre_seg got %h want %h", seg_out, es); end
            if (sel !== esl)    begin fails++; $display("FAIL mf_pre_sel got %h want %h", sel, esl); end
        end
        tests++;
        if (guard >= 4 * FRAME) begin fails++; $display("FAIL mf_align_timeout got %0d want <%0d", guard, 4 * FRAME); end
        din[3] = 8'hA5;
        for (int k = 0; k < 2 * FRAME; k++) begin
            cycle();
            tests += 3;
            if (seg_out !== es) begin fails++; $display("FAIL mf_seg k=%0d got %h want %h", k, seg_out, es); end
            if (sel !== esl)    begin fails++; $display("FAIL mf_sel k=%0d got %h want %h", k, sel, esl); end
            if (frame_tick !== et) begin fails++; $display("FAIL mf_tick k=%0d got %b want %b", k, frame_tick, et); end
            if (seg_out === 8'hA5 && sel === 6'h37) seen++;
        end
        tests++;
        if (seen != RC - (GH ? BC : 0)) begin fails++; $display("FAIL mf_a5_cycles got %0d want %0d", seen, RC - (GH ? BC : 0)); end
    endtask

    task automatic test_en_gap();
        int guard = 0;
        while ((((n / RC) % 6) != 4 || (n % RC) != 1) && guard < 4 * FRAME) begin
            cycle();
            guard++;
        end
        tests++;
        if (guard >= 4 * FRAME) begin fails++; $display("FAIL gap_align_timeout got %0d want <%0d", guard, 4 * FRAME); end
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            tests += 3;
            if (seg_out !== 8'hFF) begin fails++; $display("FAIL gap_seg k=%0d got %h want ff", k, seg_out); end
            if (sel !== 6'h3F)     begin fails++; $display("FAIL gap_sel k=%0d got %h want 3f", k, sel); end
            if (frame_tick !== 1'b0) begin fails++; $display("FAIL gap_tick k=%0d got %b want 0", k, frame_tick); end
            for (int i = 0; i < 6; i++) din[i] = 8'($urandom);
        end
        en = 1'b1;
        for (int k = 0; k < FRAME + RC; k++) begin
            cycle();
            tests += 3;
            if (seg_out !== es) begin fails++; $display("FAIL gap_re_seg k=%0d got %h want %h", k, seg_out, es); end
            if (sel !== esl)    begin fails++; $display("FAIL gap_re_sel k=%0d got %h want %h", k, sel, esl); end
            if (frame_tick !== et) begin fails++; $display("FAIL gap_re_tick k=%0d got %b want %b", k, frame_tick, et); end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < RC + 1; k++) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        tests += 3;
        if (seg_out !== 8'hFF) begin fails++; $display("FAIL ar_seg got %h want ff", seg_out); end
        if (sel !== 6'h3F)     begin fails++; $display("FAIL ar_sel got %h want 3f", sel); end
        if (frame_tick !== 1'b0) begin fails++; $display("FAIL ar_tick got %b want 0", frame_tick); end
        @(posedge clk);
        #1;
        tests += 2;
        if (seg_out !== 8'hFF) begin fails++; $display("FAIL ar_hold_seg got %h want ff", seg_out); end
        if (sel !== 6'h3F)     begin fails++; $display("FAIL ar_hold_sel got %h want 3f", sel); end
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < FRAME + RC; k++) begin
            cycle();
            tests += 3;
            if (seg_out !== es) begin fails++; $display("FAIL ar_post_seg k=%0d got %h want %h", k, seg_out, es); end
            if (sel !== esl)    begin fails++; $display("FAIL ar_post_sel k=%0d got %h want %h", k, sel, esl); end
            if (frame_tick !== et) begin fails++; $display("FAIL ar_post_tick k=%0d got %b want %b", k, frame_tick, et); end
        end
    endtask

    task automatic test_frame_tick();
        int pulses = 0;
        int last   = -1;
        for (int k = 0; k < 3 * FRAME; k++) begin
            cycle();
            tests += 2;
            if (frame_tick !== et) begin fails++; $display("FAIL ft_tick k=%0d got %b want %b", k, frame_tick, et); end
            if (sel !== esl)       begin fails++; $display("FAIL ft_sel k=%0d got %h want %h", k, sel, esl); end
            if (frame_tick === 1'b1) begin
                if (last >= 0) begin
                    tests++;
                    if (k - last != FRAME) begin fails++; $display("FAIL ft_period got %0d want %0d", k - last, FRAME); end
                end
                last = k;
                pulses++;
            end
        end
        tests++;
        if (pulses != 3) begin fails++; $display("FAIL ft_count got %0d want 3", pulses); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) din[$urandom_range(0, 5)] = 8'($urandom);
            if ($urandom_range(0, 39) == 0) en = ~en;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
            cycle();
            tests += 3;
            if (seg_out !== es) begin fails++; $display("FAIL rnd_seg k=%0d got %h want %h", k, seg_out, es); end
            if (sel !== esl)    begin fails++; $display("FAIL rnd_sel k=%0d got %h want %h", k, sel, esl); end
            if (frame_tick !== et) begin fails++; $display("FAIL rnd_tick k=%0d got %b want %b", k, frame_tick, et); end
            if (esl !== 6'h3F) begin
                tests++;
                if ($countones(~sel) != 1) begin fails++; $display("FAIL rnd_onehot k=%0d got %h want one low bit", k, sel); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frames();
        test_mid_frame_change();
        test_en_gap();
        test_async_reset();
        test_frame_tick();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Downstream consumer of the rotating-square pattern stage.
- Takes six 8-bit active-low seven-segment codes (in0..in5: bit 7 = DP, bits 6:0 = segments) and time-multiplexes them onto one shared segment bus with six active-low digit selects.
- Codes are captured into shadow registers at frame boundaries, so a pattern change never tears across one scan.
- Sits between the pattern generators and the board pins.

Parameters:
- REFRESH_CNT, 50_000: clk cycles per digit slot (1 kHz slot rate and about 167 Hz frame rate at 50 MHz). Must be >= 2.
- BLANK_CNT, 500: dead-time cycles at the start of each slot. Used only with GHOST_BLANK_EN. Must be < REFRESH_CNT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable. Low blanks the display and holds the scan at digit 0.
- in0..in5  in  8 each  active-low segment codes for digits 0..5.
- seg_out  out  8  active-low segment bus {dp, g..a}, registered.
- sel  out  6  active-low digit selects. sel[k] low drives shadow k. Registered.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: slot counter cnt = 0, digit index idx = 0, sh0..sh5 = 8'hFF, seg_out = 8'hFF, sel = 6'h3F, frame_tick = 0. Reset takes effect immediately, including mid-slot.
- cnt has width clog2(REFRESH_CNT). It counts 0..REFRESH_CNT-1 and wraps; the wrap cycle is slot_end.
- idx advances 0..5 on slot_end. On slot_end with idx = 5 it wraps to 0; that cycle is frame_end.
- Shadow capture on frame_end: sh0..sh5 <= in0..in5 and frame_tick <= 1. frame_tick is low in all other cycles.
- While en = 0:
  - cnt and idx are cleared to 0.
  - Shadows load in0..in5 every cycle.
  - seg_out <= 8'hFF, sel <= 6'h3F, frame_tick = 0.
- While en = 1:
  - seg_out <= sh[idx].
  - sel <= ~(6'b1 << idx).
  - Outputs lag idx by one cycle. Exactly one sel bit is low at any time.
- en rising:
  - The first clock edge with en = 1 drives digit 0 from the shadows loaded in the previous cycle.
  - cnt counts from 0, so the first slot is a full REFRESH_CNT cycles.
- en falling mid-slot: at the next edge the outputs blank and cnt/idx return to 0. No partial-frame capture.
- Inputs changing mid-frame have no visible effect until the next frame_end.
- Simultaneous frame_end and en falling: en = 0 has priority. Shadows load anyway (en = 0 loads every cycle); frame_tick is not asserted.

Optional Feature:
- Macro: GHOST_BLANK_EN.
- Defined:
  - While en = 1 and cnt < BLANK_CNT, the block forces seg_out = 8'hFF and sel = 6'h3F.
  - For the rest of the slot it drives normally.
  - This removes ghosting from slow digit drivers.
  - Visible on-time per slot is REFRESH_CNT - BLANK_CNT cycles.
- Undefined: BLANK_CNT is ignored and each digit is driven for its whole slot.
- idx, frame_end and frame_tick timing are identical in both builds.

Decomposition:
- Package seg7_pkg holds:
  - SEG_OFF = 8'hFF, SEL_OFF = 6'h3F, NUM_DIG = 6.
  - Function sel_decode(idx) returning the active-low one-hot select.
- One sub-module, seg7_scan_prescaler:
  - Implements cnt with REFRESH_CNT as a parameter and a synchronous clear driven by en.
  - Outputs cnt and slot_end.
  - Top level owns idx, the shadows and the output registers.

Test Plan:
- Reset, then run with REFRESH_CNT = 4, en = 1, in0..in5 = 8'h01..8'h06 applied before the first frame_end:
  - First frame: seg_out = 8'hFF for digits 0..5, sel cycling 3E, 3D, 3B, 37, 2F, 1F, each held 4 cycles.
  - After frame_tick: seg_out = 01..06 in the same order.
- Change in3 to 8'hA5 mid-frame (idx = 1): 8'hA5 appears only in the next frame's digit-3 slot. The current frame still shows the old value.
- en low for 10 cycles mid-slot (idx = 4), then high:
  - Next edge after en falls: seg_out = FF, sel = 3F, frame_tick = 0.
  - After en rises: scan restarts at sel = 3E with the current inputs, and digit 0 lasts 4 cycles.
- Assert rst_n low mid-slot: seg_out = FF and sel = 3F immediately, before any clock edge. After release, the scan resumes from idx 0 with shadows = FF.
- frame_tick check over 3 frames: exactly one pulse every 24 cycles, coincident with the idx 5 -> 0 transition.
- GHOST_BLANK_EN defined, REFRESH_CNT = 8, BLANK_CNT = 3: each slot shows 3 cycles of sel = 3F, then 5 cycles of the selected digit. Frame period stays 48 cycles.
